// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - pitch codes, 50 MHz divider table, default song and FSM state type
package melody_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [3:0] P_REST = 4'd0;
   localparam logic [3:0] P_A4   = 4'd1;
   localparam logic [3:0] P_AS4  = 4'd2;
   localparam logic [3:0] P_B4   = 4'd3;
   localparam logic [3:0] P_C5   = 4'd4;
   localparam logic [3:0] P_CS5  = 4'd5;
   localparam logic [3:0] P_D5   = 4'd6;
   localparam logic [3:0] P_DS5  = 4'd7;
   localparam logic [3:0] P_E5   = 4'd8;
   localparam logic [3:0] P_F5   = 4'd9;
   localparam logic [3:0] P_FS5  = 4'd10;
   localparam logic [3:0] P_G5   = 4'd11;
   localparam logic [3:0] P_GS5  = 4'd12;
   localparam logic [3:0] P_A5   = 4'd13;

   // Half-period reload at 50 MHz: round(50e6/(2f)) - 1; rest and unused codes give 0.
   function automatic logic [15:0] pitch_div(input logic [3:0] pitch);
      case (pitch)
         P_A4:    return 16'd56817;
         P_AS4:   return 16'd53628;
         P_B4:    return 16'd50618;
         P_C5:    return 16'd47777;
         P_CS5:   return 16'd45095;
         P_D5:    return 16'd42565;
         P_DS5:   return 16'd40176;
         P_E5:    return 16'd37921;
         P_F5:    return 16'd35792;
         P_FS5:   return 16'd33783;
         P_G5:    return 16'd31887;
         P_GS5:   return 16'd30097;
         P_A5:    return 16'd28408;
         default: return 16'd0;
      endcase
   endfunction

   // Entry format {pitch, dur}; note lasts (dur+1) beat ticks.
   function automatic logic [7:0] song_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    return {P_A4,   4'd1};
         4'd1:    return {P_CS5,  4'd3};
         4'd2:    return {P_REST, 4'd0};
         4'd3:    return {P_A5,   4'd1};
         default: return {P_REST, 4'd0};
      endcase
   endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - control and tone-output bundle; MELODY_OCTAVE_EN adds octave_up
interface melody_sequencer_if #(
   parameter int DIV_W = 16
);
   logic             start;
   logic             stop;
   logic             loop;
`ifdef MELODY_OCTAVE_EN
   logic             octave_up;
`endif
   logic [DIV_W-1:0] half_period;
   logic             mute;
   logic             busy;
   logic [3:0]       note_idx;
   logic             note_strobe;

`ifdef MELODY_OCTAVE_EN
   modport master (
      output start, stop, loop, octave_up,
      input  half_period, mute, busy, note_idx, note_strobe
   );
   modport slave (
      input  start, stop, loop, octave_up,
      output half_period, mute, busy, note_idx, note_strobe
   );
`else
   modport master (
      output start, stop, loop,
      input  half_period, mute, busy, note_idx, note_strobe
   );
   modport slave (
      input  start, stop, loop,
      output half_period, mute, busy, note_idx, note_strobe
   );
`endif
endinterface

// File: rtl/pitch_to_div.sv
// rtl/pitch_to_div.sv - combinational pitch code to half-period divider map
module pitch_to_div
   import melody_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic [3:0]       i_pitch,
   output logic [DIV_W-1:0] o_div,
   output logic             o_mute
);
   logic [15:0] w_div16;

   // A zero divider marks both the rest code and unused codes as silent.
   always_comb begin
      w_div16 = pitch_div(i_pitch);
      o_div   = DIV_W'(w_div16);
      o_mute  = (w_div16 == 16'd0);
   end
endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps the song table and drives half_period/mute to the tone generator
// Optional MELODY_OCTAVE_EN: octave_up at note load halves the period.
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int TICK_HZ   = 16,
   parameter int GAP_CYC   = 500000,
   parameter int NUM_NOTES = 4,
   parameter int DIV_W     = 16
) (
   input  logic               osc_CLK,
   input  logic               rst_n,
   melody_sequencer_if.slave  bus
);
   localparam int TICK_CYC = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
   localparam int GAP_C    = (GAP_CYC > 0) ? GAP_CYC : 1;
   localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam int GW       = (GAP_C > 1) ? $clog2(GAP_C) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_C - 1);
   localparam logic [3:0]    LAST_IDX   = 4'(NUM_NOTES - 1);

   state_t           r_state;
   logic [3:0]       r_idx;
   logic [3:0]       r_dur;
   logic [3:0]       r_dur_cnt;
   logic [PW-1:0]    r_presc;
   logic [GW-1:0]    r_gap;
   logic [DIV_W-1:0] r_half;
   logic             r_mute;
   logic             r_busy;
   logic             r_strobe;

   logic [3:0]       w_load_idx;
   logic [7:0]       w_entry;
   logic [DIV_W-1:0] w_div;
   logic [DIV_W-1:0] w_div_load;
   logic             w_rest;
   logic             w_gap_done;
   logic             w_do_load;

   always_comb begin
      w_load_idx = 4'd0;
      if (r_state == GAP && r_idx < LAST_IDX) begin
         w_load_idx = r_idx + 4'd1;
      end
      w_entry = song_entry(w_load_idx);
   end

   pitch_to_div #(.DIV_W(DIV_W)) u_pitch_to_div (
      .i_pitch (w_entry[7:4]),
      .o_div   (w_div),
      .o_mute  (w_rest)
   );

`ifdef MELODY_OCTAVE_EN
   logic [DIV_W:0] w_div_inc;

   always_comb begin
      w_div_inc  = {1'b0, w_div} + (DIV_W+1)'(1);
      w_div_load = (bus.octave_up && !w_rest) ? w_div_inc[DIV_W:1] - DIV_W'(1) : w_div;
   end
`else
   always_comb begin
      w_div_load = w_div;
   end
`endif

   // stop outranks every load, including the end-of-gap advance.
   always_comb begin
      w_gap_done = (r_gap == GAP_LAST);
      w_do_load  = !bus.stop &&
                   ((r_state == IDLE && bus.start) ||
                    (r_state == GAP && w_gap_done && (r_idx < LAST_IDX || bus.loop)));
   end

   always_ff @(posedge osc_CLK) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_idx     <= 4'd0;
         r_dur     <= 4'd0;
         r_dur_cnt <= 4'd0;
         r_presc   <= '0;
         r_gap     <= '0;
         r_half    <= '0;
         r_mute    <= 1'b1;
         r_busy    <= 1'b0;
         r_strobe  <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         case (r_state)
            IDLE: r_mute <= 1'b1;
            PLAY: begin
               if (bus.stop) begin
                  r_state <= IDLE;
                  r_mute  <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (r_presc == PRESC_LAST) begin
                  r_presc <= '0;
                  if (r_dur_cnt == r_dur) begin
                     r_state <= GAP;
                     r_mute  <= 1'b1;
                     r_gap   <= '0;
                  end else begin
                     r_dur_cnt <= r_dur_cnt + 4'd1;
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end
            GAP: begin
               if (bus.stop || w_gap_done) begin
                  r_state <= IDLE;
                  r_mute  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase

         // A load overrides the end-of-gap exit above; rests keep the previous divider.
         if (w_do_load) begin
            r_state   <= PLAY;
            r_idx     <= w_load_idx;
            r_dur     <= w_entry[3:0];
            r_presc   <= '0;
            r_dur_cnt <= 4'd0;
            r_strobe  <= 1'b1;
            r_busy    <= 1'b1;
            r_mute    <= w_rest;
            if (!w_rest) begin
               r_half <= w_div_load;
            end
         end
      end
   end

   assign bus.half_period = r_half;
   assign bus.mute        = r_mute;
   assign bus.busy        = r_busy;
   assign bus.note_idx    = r_idx;
   assign bus.note_strobe = r_strobe;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - randomized scoreboard bench for melody_sequencer
module tb_melody_sequencer;
   localparam int CLK_HZ = 1000;
   localparam int TICK_HZ = 100;
   localparam int TICK = CLK_HZ / TICK_HZ;
   localparam int GAPC = 2;
   localparam int NUM = 4;
   localparam int BIG = 1 << 30;

   typedef struct {int cyc; int idx; int half; bit mute;} load_t;
   typedef struct {int cyc; bit mute; bit busy;} lvl_t;

   logic osc_CLK = 1'b0;
   logic rst_n = 1'b0;
   always #5 osc_CLK = ~osc_CLK;

   melody_sequencer_if #(.DIV_W(16)) bus ();

   melody_sequencer #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .GAP_CYC(GAPC), .NUM_NOTES(NUM), .DIV_W(16)
   ) dut (
      .osc_CLK (osc_CLK),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   logic [1:0] prev_mb;
   load_t load_q[$];
   lvl_t  lvl_q[$];

   int song_p[NUM] = '{1, 5, 0, 13};
   int song_d[NUM] = '{1, 3, 0, 1};
   int song_total;
   int m_half = 0;
   bit m_mute = 1'b1;
   bit m_busy = 1'b0;

   always @(posedge osc_CLK) cyc <= cyc + 1;

   function automatic int div_of(input int p);
      case (p)
         1:       return 56817;
         5:       return 45095;
         13:      return 28408;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   task automatic model_level(input int t, input bit mu, input bit bu);
      if (mu != m_mute || bu != m_busy) lvl_q.push_back('{t, mu, bu});
      m_mute = mu;
      m_busy = bu;
   endtask

   // Timeline of a playback starting at c0, cut short by stop/reset taking effect at limit.
   task automatic model_play(input int c0, input int nloads, input int limit);
      int t, i, tend;
      bit cut;
      t = c0;
      cut = 1'b0;
      for (int k = 0; k < nloads; k++) begin
         i = k % NUM;
         if (t >= limit) begin cut = 1'b1; break; end
         if (song_p[i] != 0) m_half = div_of(song_p[i]);
         load_q.push_back('{t, i, m_half, song_p[i] == 0});
         model_level(t, song_p[i] == 0, 1'b1);
         tend = t + (song_d[i] + 1) * TICK;
         if (tend >= limit) begin cut = 1'b1; break; end
         model_level(tend, 1'b1, 1'b1);
         t = tend + GAPC;
      end
      if (cut) model_level(limit, 1'b1, 1'b0);
      else model_level(t, 1'b1, 1'b0);
   endtask

   always @(negedge osc_CLK) begin : monitor
      load_t le;
      lvl_t ve;
      if (mon_en) begin
         if (bus.note_strobe === 1'b1) begin
            if (load_q.size() == 0) chk("spurious_strobe", 1, 0);
            else begin
               le = load_q.pop_front();
               chk("load_cycle", cyc, le.cyc);
               chk("load_idx", bus.note_idx, le.idx);
               chk("load_half", bus.half_period, le.half);
               chk("load_mute", bus.mute, le.mute);
               chk("load_busy", bus.busy, 1);
            end
         end
         if ({bus.mute, bus.busy} !== prev_mb) begin
            if (lvl_q.size() == 0) chk("spurious_mute_busy_change", {bus.mute, bus.busy}, prev_mb);
            else begin
               ve = lvl_q.pop_front();
               chk("level_cycle", cyc, ve.cyc);
               chk("level_mute", bus.mute, ve.mute);
               chk("level_busy", bus.busy, ve.busy);
            end
         end
         prev_mb = {bus.mute, bus.busy};
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge osc_CLK); #1; end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin @(posedge osc_CLK); #1; end
   endtask

   task automatic issue(input bit s, input bit p);
      bus.start = s;
      bus.stop = p;
      @(posedge osc_CLK); #1;
      bus.start = 1'b0;
      bus.stop = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((load_q.size() != 0 || lvl_q.size() != 0) && n < 500) begin
         @(posedge osc_CLK); #1;
         n++;
      end
      chk("pending_expected", load_q.size() + lvl_q.size(), 0);
      load_q.delete();
      lvl_q.delete();
   endtask

   task automatic run_scn(input bit lp, input bit use_stop, input int stop_off, input bit inj);
      int c0, limit, busy_end, target;
      bus.loop = lp;
      c0 = cyc + 1;
      limit = use_stop ? c0 + stop_off : BIG;
      busy_end = lp ? limit : ((c0 + song_total < limit) ? c0 + song_total : limit);
      model_play(c0, lp ? 30 : NUM, limit);
      issue(1'b1, 1'b0);
      target = use_stop ? limit - 1 : busy_end;
      while (cyc < target) begin
         if (inj && cyc + 1 < busy_end && (cyc + 1 == c0 + 5 || $urandom_range(0, 29) == 0))
            issue(1'b1, 1'b0);
         else
            tick(1);
      end
      if (use_stop) issue(1'($urandom_range(0, 1)), 1'b1);
      drain();
      bus.loop = 1'b0;
   endtask

   initial begin
      int c0;
      bit lp, us;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.loop = 1'b0;
`ifdef MELODY_OCTAVE_EN
      bus.octave_up = 1'b0;
`endif
      song_total = 0;
      for (int i = 0; i < NUM; i++) song_total += (song_d[i] + 1) * TICK + GAPC;

      repeat (2) @(posedge osc_CLK);
      @(negedge osc_CLK);
      chk("reset_half", bus.half_period, 0);
      chk("reset_mute", bus.mute, 1);
      chk("reset_busy", bus.busy, 0);
      chk("reset_idx", bus.note_idx, 0);
      chk("reset_strobe", bus.note_strobe, 0);
      @(posedge osc_CLK); #1;
      rst_n = 1'b1;
      prev_mb = {bus.mute, bus.busy};
      mon_en = 1'b1;
      tick(3);

      run_scn(1'b0, 1'b0, 0, 1'b1);
      tick(4);
      run_scn(1'b1, 1'b1, song_total + 5, 1'b1);

      issue(1'b1, 1'b1);
      tick(30);
      chk("idle_start_stop_busy", bus.busy, 0);

      run_scn(1'b0, 1'b1, 40, 1'b0);
      run_scn(1'b0, 1'b0, 0, 1'b0);

      c0 = cyc + 1;
      model_play(c0, NUM, c0 + 21);
      issue(1'b1, 1'b0);
      wait_cyc(c0 + 20);
      rst_n = 1'b0;
      @(posedge osc_CLK); #1;
      rst_n = 1'b1;
      m_half = 0;
      @(negedge osc_CLK);
      chk("gap_reset_half", bus.half_period, 0);
      chk("gap_reset_idx", bus.note_idx, 0);
      chk("gap_reset_strobe", bus.note_strobe, 0);
      chk("gap_reset_mute", bus.mute, 1);
      chk("gap_reset_busy", bus.busy, 0);
      drain();

      repeat (10) begin
         lp = 1'($urandom_range(0, 1));
         us = lp | 1'($urandom_range(0, 1));
         run_scn(lp, us, $urandom_range(1, 260), 1'b1);
         tick($urandom_range(0, 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end
endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage of the square-wave tone generator.
- Steps through a fixed note table and, for each note, presents the half-period reload value (`half_period`) and a `mute` flag. The tone generator consumes both to toggle its speaker pin.
- Note durations are timed in beat ticks derived from `osc_CLK`. A short muted articulation gap separates consecutive notes.

Parameters:
- `CLK_HZ`, 50000000, frequency of `osc_CLK` in Hz.
- `TICK_HZ`, 16, beat-tick rate; `TICK_CYC = CLK_HZ/TICK_HZ` clocks per tick.
- `GAP_CYC`, 500000, clocks of forced mute between notes; minimum 1.
- `NUM_NOTES`, 4, number of entries in the song table; 1..16.
- `DIV_W`, 16, width of `half_period`.

Ports:
- `osc_CLK`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  one-cycle pulse; begins playback from note 0 when idle.
- `stop`  in  1  one-cycle pulse; aborts playback.
- `loop`  in  1  level; when 1, wrap to note 0 after the last note.
- `half_period`  out  DIV_W  consumer counter reload value, equal to `CLK_HZ/(2f)-1`.
- `mute`  out  1  1 means the consumer must not toggle its output.
- `busy`  out  1  1 while in `PLAY` or `GAP`.
- `note_idx`  out  4  index of the current note.
- `note_strobe`  out  1  one-cycle pulse on every note load.

Behaviour:
- Reset (`rst_n`=0 at a clock edge): state `IDLE`, `half_period`=0, `mute`=1, `busy`=0, `note_idx`=0, `note_strobe`=0, all counters cleared. Reset mid-note takes effect at the next edge.
- Song entry format: 8 bits, `{pitch[3:0], dur[3:0]}`.
  - Note length is `(dur+1)*TICK_CYC` clocks.
  - `pitch` 0 is a rest: `mute`=1 for the whole note, `half_period` holds its previous value.
- FSM states: `IDLE`, `PLAY`, `GAP`.
- `IDLE`:
  - `mute`=1.
  - When `start`=1 and `stop`=0: load note 0.
  - Registered outputs update on the following edge: `note_strobe`=1, `half_period`=table divider, `mute` = (pitch==0), `busy`=1.
  - Tick prescaler and duration counter are cleared on the load.
  - Next state: `PLAY`.
- `PLAY`:
  - Prescaler counts 0..`TICK_CYC`-1; the duration counter increments on each wrap.
  - After exactly `(dur+1)*TICK_CYC` clocks from the load cycle, go to `GAP` with `mute`=1.
- `GAP`:
  - After exactly `GAP_CYC` clocks, take the next action:
    - if `note_idx` < `NUM_NOTES`-1: load `note_idx`+1 and go to `PLAY`;
    - else if `loop`=1: load note 0 and go to `PLAY`;
    - else: go to `IDLE` (`busy`=0, `half_period` held).
  - `loop` is sampled only at this decision point.
- `stop` in `PLAY` or `GAP`: next edge enters `IDLE` with `mute`=1, `busy`=0 and `note_idx` held.
- `start` while busy is ignored.
- `start` and `stop` in the same cycle: `stop` wins, no load.
- `note_strobe` is never asserted in `IDLE`.
- Lookup latency:
  - divider lookup is combinational from `pitch`;
  - all outputs are registered;
  - 1 clock from `start` to first valid `half_period`.

Optional Feature:
- Macro: `MELODY_OCTAVE_EN`.
- Defined:
  - adds input port `octave_up` (1 bit);
  - when 1 at note load, `half_period` = `((table_div+1)>>1)-1`, one octave higher;
  - sampled only at note load.
- Undefined: the port is absent and `half_period` = `table_div` always.

Decomposition:
- Package `melody_pkg` holds:
  - pitch code constants: `P_REST`=0; `P_A4`=1 .. `P_GS5`=12 (semitones); `P_A5`=13;
  - divider table for 50 MHz: A4 = 56817, C#5 = 45095, A5 = 28408, others equal-tempered and rounded;
  - the default song: `{P_A4,1}`, `{P_CS5,3}`, `{P_REST,0}`, `{P_A5,1}`;
  - `state_t` enum.
- Sub-module `pitch_to_div`: combinational map from 4-bit pitch code to `DIV_W` divider. Unused codes map to 0 with mute forced to 1.

Test Plan (`CLK_HZ`=1000, `TICK_HZ`=100 so `TICK_CYC`=10, `GAP_CYC`=2):
- Start after reset: pulse `start` → 1 clock later `half_period`=56817, `mute`=0, `busy`=1, `note_strobe` single pulse, `note_idx`=0; `mute` rises after 20 clocks.
- Full song, `loop`=0:
  - note 1 plays 45095 for 40 clocks;
  - rest note has `mute`=1 for 10 clocks with `half_period`=45095 held;
  - A5 (28408) plays 20 clocks;
  - after the final gap, `busy`=0 and total time from first load is 98 clocks.
- `loop`=1: after note 3's gap, `note_idx` returns to 0, `half_period`=56817 and `note_strobe` pulses; `busy` never drops.
- `stop` in mid-note 1 → next clock `mute`=1, `busy`=0; a `start` pulse in the same cycle as `stop` is ignored; a later `start` restarts at note 0.
- `rst_n`=0 during `GAP` → next clock all outputs at reset values; a `start` pulse while busy is ignored, with no strobe.
- With `MELODY_OCTAVE_EN` defined and `octave_up`=1: note 0 gives `half_period`=28408; toggling `octave_up` mid-note has no effect until the next load.
